// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - four-digit multiplexed seven-segment scanner with frame-aligned input capture
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [0:6] D1,
  input  logic [0:6] D2,
  input  logic [0:6] D3,
  input  logic [0:6] D4,
  output logic [0:6] SEG,
  output logic [3:0] AN,
  output logic       frame_done
);

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [0:6]       BLANK   = 7'h7F;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             running_q, running_d;
  logic [0:6]       sh_q [4];
  logic [0:6]       sh_d [4];
  logic [0:6]       disp [4];
  logic [3:0]       an_q, an_d;
  logic [0:6]       seg_q, seg_d;
  logic             fd_q, fd_d;
  logic             tick;

  assign tick       = en && (cnt_q == CNT_MAX);
  assign SEG        = seg_q;
  assign AN         = an_q;
  assign frame_done = fd_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic blank4, blank3, blank2;
  always_comb begin
    // A digit is blanked only if it is "0" and every more-significant digit is blanked too.
    blank4  = (sh_q[3] == 7'h01);
    blank3  = blank4 && (sh_q[2] == 7'h01);
    blank2  = blank3 && (sh_q[1] == 7'h01);
    disp[0] = sh_q[0];
    disp[1] = blank2 ? BLANK : sh_q[1];
    disp[2] = blank3 ? BLANK : sh_q[2];
    disp[3] = blank4 ? BLANK : sh_q[3];
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) disp[i] = sh_q[i];
  end
`endif

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    running_d = running_q;
    sh_d      = sh_q;
    an_d      = 4'hF;
    seg_d     = BLANK;
    fd_d      = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      idx_d     = 2'd0;
      running_d = 1'b0;
    end else begin
      cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      running_d = 1'b1;
      if (!running_q) begin
        // First enabled cycle shows the freshly captured units digit, avoiding a blank slot.
        sh_d  = '{D1, D2, D3, D4};
        an_d  = 4'b1110;
        seg_d = D1;
      end else begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = disp[idx_q];
        if (tick && (idx_q == 2'd3)) begin
          sh_d = '{D1, D2, D3, D4};
          fd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      running_q <= 1'b0;
      for (int i = 0; i < 4; i++) sh_q[i] <= BLANK;
      an_q      <= 4'hF;
      seg_q     <= BLANK;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      running_q <= running_d;
      sh_q      <= sh_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - scoreboard bench for seg7_scan_mux (SCAN_DIV=4 and SCAN_DIV=1)
module tb_seg7_scan_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [0:6] seg;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, en1;
  logic [0:6] d1, d2, d3, d4;
  logic [0:6] seg, seg1;
  logic [3:0] an, an1;
  logic       fd, fd1;
  logic       mon_on = 1'b0;
  logic [0:6] pat [4];
  exp_t       exp_q [$];
  int         total = 0;
  int         bad   = 0;

  seg7_scan_mux #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .D1(d1), .D2(d2), .D3(d3), .D4(d4),
    .SEG(seg), .AN(an), .frame_done(fd)
  );

  seg7_scan_mux #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1),
    .D1(d1), .D2(d2), .D3(d3), .D4(d4),
    .SEG(seg1), .AN(an1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ($countones(~an) > 1 || $countones(~an1) > 1) begin
        bad++;
        $display("FAIL onehot: an=%b an1=%b, required at most one low bit", an, an1);
      end
    end
  end

  function automatic exp_t exp_scan(int k);
    exp_t       e;
    logic [3:0] one = 4'b0001;
    int         dg  = (k / 4) % 4;
    e.an  = ~(one << dg);
    e.seg = pat[dg];
    e.fd  = ((k % 16) == 15);
    return e;
  endfunction

  function automatic exp_t exp_blank();
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fd  = 1'b0;
    return e;
  endfunction

  task automatic set_digits(input logic [0:6] a, input logic [0:6] b,
                            input logic [0:6] c, input logic [0:6] d);
    d1 = a; d2 = b; d3 = c; d4 = d;
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
  endtask

  task automatic step(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({an, seg, fd} !== {e.an, e.seg, e.fd}) begin
        bad++;
        $display("FAIL %s: got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 name, an, seg, fd, e.an, e.seg, e.fd);
      end
    end
  endtask

  task automatic stop_scan();
    en = 1'b0;
    exp_q.push_back(exp_blank());
    step("disable");
  endtask

  task automatic run_scan(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp_scan(k));
      step(name);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({an, seg, fd} !== {4'hF, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, fd);
    end
    mon_on = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({an, seg} !== {4'b1110, 7'h4F}) begin
      bad++;
      $display("FAIL first_edge: got an=%b seg=%h, want an=1110 seg=4f", an, seg);
    end
    stop_scan();
  endtask

  task automatic test_scan();
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    en = 1'b1;
    run_scan("scan", 32);
    stop_scan();
  endtask

  task automatic test_mid_change();
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 16) pat[1] = 7'h00;
      exp_q.push_back(exp_scan(k));
      step("mid_change");
      if (k == 5) d2 = 7'h00;
    end
    stop_scan();
  endtask

  task automatic test_en_drop();
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    en = 1'b1;
    run_scan("pre_drop", 9);
    en = 1'b0;
    d1 = 7'h30;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_blank());
      step("en_low");
    end
    pat[0] = 7'h30;
    en = 1'b1;
    run_scan("re_enable", 16);
    stop_scan();
  endtask

  task automatic test_reset_mid();
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    en = 1'b1;
    run_scan("pre_reset", 15);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, fd} !== {4'hF, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, fd);
    end
    @(posedge clk);
    #1;
    total++;
    if ({an, fd} !== {4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_no_pulse: got an=%b fd=%b, want an=1111 fd=0", an, fd);
    end
    en = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(exp_blank());
    step("post_reset_idle");
  endtask

  task automatic test_blank();
    set_digits(7'h01, 7'h0F, 7'h01, 7'h01);
`ifdef LEADING_ZERO_BLANK_EN
    pat[2] = 7'h7F;
    pat[3] = 7'h7F;
`endif
    en = 1'b1;
    run_scan("blank_0070", 16);
    stop_scan();
    set_digits(7'h01, 7'h01, 7'h01, 7'h01);
`ifdef LEADING_ZERO_BLANK_EN
    pat[1] = 7'h7F;
    pat[2] = 7'h7F;
    pat[3] = 7'h7F;
`endif
    en = 1'b1;
    run_scan("blank_0000", 16);
    stop_scan();
  endtask

  task automatic test_div1();
    logic [3:0] one = 4'b0001;
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    en1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({an1, seg1, fd1} !== {~(one << (k % 4)), pat[k % 4], ((k % 4) == 3)}) begin
        bad++;
        $display("FAIL div1 k=%0d: got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 k, an1, seg1, fd1, ~(one << (k % 4)), pat[k % 4], ((k % 4) == 3));
      end
    end
    en1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({an1, seg1, fd1} !== {4'hF, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL div1_disable: got an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an1, seg1, fd1);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    en1   = 1'b0;
    set_digits(7'h4F, 7'h12, 7'h06, 7'h4C);
    #2;
    test_reset();
    test_scan();
    test_mid_change();
    test_en_drop();
    test_reset_mid();
    test_blank();
    test_div1();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  scan enable; low blanks the display.
REQ-005 SHALL have ports D1, D2, D3, D4  input  7 each, [0:6]  active-low segment patterns (bit0=a .. bit6=g) for units, tens, hundreds, thousands.
REQ-006 SHALL have port SEG  output  7, [0:6]  shared active-low segment bus, registered.
REQ-007 SHALL have port AN  output  4  active-low digit enables, AN[0]=D1 .. AN[3]=D4, registered.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse per completed 4-digit frame, registered.

Function
REQ-009 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1; tick = (cnt==SCAN_DIV-1); cnt wraps to 0 on tick. With SCAN_DIV=1, tick is high every running cycle.
REQ-010 SHALL keep a digit index idx 0..3 that advances on tick and wraps 3->0.
REQ-011 SHALL keep a flag running: cleared by reset or en=0; set on the first cycle with en=1.
REQ-012 While en=0: cnt=0, idx=0, running=0; on the next edge AN=4'hF, SEG=7'h7F, frame_done=0.
REQ-013 SHALL capture D1..D4 into four shadow registers on the first enabled cycle (en=1, running=0) and on every frame wrap (tick with idx==3); otherwise the shadow registers hold, so input changes mid-frame are never displayed.
REQ-014 While running, SHALL register AN = ~(4'b0001<<idx) and SEG = shadow[idx] (after blanking per REQ-022). Outputs reflect a new idx one cycle after the edge that changed it.
REQ-015 In the first enabled cycle, SHALL load the outputs from the D inputs being captured, so the first-frame digit 0 shows fresh data with no blank slot.
REQ-016 SHALL ensure exactly one AN bit is low while running and never more than one in any cycle.
REQ-017 frame_done SHALL pulse high on the edge after the tick with idx==3, coinciding with the shadow update; it SHALL not pulse while en=0.
REQ-018 If en falls mid-frame, SHALL blank on the next edge with no frame_done; when en returns, scan SHALL restart at digit 0 with a fresh capture.

Reset
REQ-019 rst_n low SHALL asynchronously force cnt=0, idx=0, running=0, shadows=7'h7F, AN=4'hF, SEG=7'h7F, frame_done=0.
REQ-020 After rst_n deasserts, SHALL remain idle until a clock edge with en=1; assertion mid-frame SHALL abort immediately with no partial pulse.

Configuration
REQ-021 Macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking at compile time.
REQ-022 When defined: D4 is blanked (7'h7F) if its shadow equals 7'h01 ("0"); D3 likewise if D4 is also blanked; D2 likewise if D3 is also blanked; D1 is never blanked. When undefined: all shadow patterns are shown unmodified, with no extra logic.

Verification (SCAN_DIV=4 unless stated)
REQ-023 Reset with en=1 held -> AN=4'hF, SEG=7'h7F; first edge after release -> AN=4'b1110, SEG=D1.
REQ-024 D1..D4 = 7'h4F, 7'h12, 7'h06, 7'h4C ("1234" order units first) -> AN sequence 1110, 1101, 1011, 0111 with matching SEG, 4 cycles each; frame_done high once every 16 cycles.
REQ-025 Change D2 to 7'h00 mid-frame -> SEG for digit 1 unchanged until after the next frame_done, then 7'h00.
REQ-026 Drop en at idx=2 for 3 cycles -> AN=4'hF, SEG=7'h7F, no frame_done; on re-enable, AN=4'b1110 on the first edge.
REQ-027 With LEADING_ZERO_BLANK_EN, inputs "0 0 7 0" (D4..D1 = 7'h01, 7'h01, 7'h0F, 7'h01) -> D4 slot SEG=7'h7F, D3 slot SEG=7'h7F, D2 slot SEG=7'h0F, D1 slot SEG=7'h01; all zeros -> only D1 shows 7'h01. Without the macro -> all four slots show their patterns.
REQ-028 SCAN_DIV=1 -> AN changes every cycle and frame_done pulses every 4 cycles; assert at most one AN bit low in every cycle for all tests.
